// File: rtl/regbank_dump_tx_if.sv
// Bundle between the register-dump reader, the bank debug read port and the UART byte port.
// Handshakes: i_start is a one-cycle request honoured only while idle; o_tx_start is a one-cycle
// byte strobe and i_tx_done the one-cycle completion strobe that the block waits for before the
// next byte; i_rb_data is valid the cycle after o_rb_read_enable.
interface regbank_dump_tx_if #(
  parameter int DATA_SIZE = 32,
  parameter int REG_SIZE  = 5,
  parameter int BYTE_SIZE = 8
);
  logic                 i_start;
  logic                 o_rb_read_enable;
  logic [REG_SIZE-1:0]  o_rb_read_addr;
  logic [DATA_SIZE-1:0] i_rb_data;
  logic [BYTE_SIZE-1:0] o_tx_data;
  logic                 o_tx_start;
  logic                 i_tx_done;
  logic                 o_busy;
  logic                 o_done;
  logic [2:0]           dbg_state;

  modport slave (
    input  i_start,
    input  i_rb_data,
    input  i_tx_done,
    output o_rb_read_enable,
    output o_rb_read_addr,
    output o_tx_data,
    output o_tx_start,
    output o_busy,
    output o_done,
    output dbg_state
  );

  modport master (
    output i_start,
    output i_rb_data,
    output i_tx_done,
    input  o_rb_read_enable,
    input  o_rb_read_addr,
    input  o_tx_data,
    input  o_tx_start,
    input  o_busy,
    input  o_done,
    input  dbg_state
  );
endinterface

// File: rtl/regbank_dump_tx.sv
// Walks the register bank through its debug read port and streams every word, MSB byte first,
// into the UART transmitter; pulses o_done after the last byte is acknowledged.
module regbank_dump_tx #(
  parameter int DATA_SIZE = 32,
  parameter int REG_SIZE  = 5,
  parameter int NUM_REGS  = 32,
  parameter int BYTE_SIZE = 8
) (
  input  logic           i_clock,
  input  logic           i_reset,
  regbank_dump_tx_if.slave bus
);

  localparam int BYTES = DATA_SIZE / BYTE_SIZE;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0]    LAST_BYTE = CNT_W'(BYTES - 1);
  localparam logic [REG_SIZE-1:0] LAST_IDX  = REG_SIZE'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_LATCH   = 3'd2,
    ST_SEND    = 3'd3,
    ST_WAIT_TX = 3'd4,
    ST_NEXT    = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  state_t               state_q, state_d;
  logic [REG_SIZE-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_SIZE-1:0] shift_q, shift_d;
  logic [BYTE_SIZE-1:0] tx_data_q, tx_data_d;
  logic                 rd_en;
  logic                 tx_start;
  logic                 done;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      shift_q   <= '0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      tx_data_q <= tx_data_d;
    end
  end

  // The byte register is loaded on the edge that enters SEND, so the byte is stable for the whole
  // strobe cycle and then held until the next SEND.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    tx_data_d = tx_data_q;
    rd_en     = 1'b0;
    tx_start  = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          idx_d   = '0;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        rd_en   = 1'b1;
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        shift_d   = bus.i_rb_data;
        cnt_d     = '0;
        tx_data_d = bus.i_rb_data[DATA_SIZE-1 -: BYTE_SIZE];
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        tx_start = 1'b1;
        state_d  = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (bus.i_tx_done) begin
          if (cnt_q == LAST_BYTE) begin
            state_d = ST_NEXT;
          end else begin
            shift_d   = shift_q << BYTE_SIZE;
            cnt_d     = cnt_q + CNT_W'(1);
            tx_data_d = shift_d[DATA_SIZE-1 -: BYTE_SIZE];
            state_d   = ST_SEND;
          end
        end
      end
      ST_NEXT: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + REG_SIZE'(1);
          state_d = ST_READ;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Address is forced to zero outside READ so the bank port sees a quiet bus when not reading.
  assign bus.o_rb_read_enable = rd_en;
  assign bus.o_rb_read_addr   = rd_en ? idx_q : '0;
  assign bus.o_tx_start       = tx_start;
  assign bus.o_tx_data        = tx_data_q;
  assign bus.o_busy           = (state_q != ST_IDLE);
  assign bus.o_done           = done;
  assign bus.dbg_state        = state_q;

endmodule

// File: tb/tb_regbank_dump_tx.sv
// Randomized scoreboard bench for regbank_dump_tx: a bank model, a UART ack model, a byte monitor
// and a NUM_REGS=1 / 16-bit corner instance.
module tb_regbank_dump_tx;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int BW = 8;
  localparam int NR = 32;
  localparam int NB = DW / BW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regbank_dump_tx_if #(.DATA_SIZE(DW), .REG_SIZE(RW), .BYTE_SIZE(BW)) bus ();
  regbank_dump_tx #(.DATA_SIZE(DW), .REG_SIZE(RW), .NUM_REGS(NR), .BYTE_SIZE(BW)) dut (
    .i_clock(clk), .i_reset(rst), .bus(bus)
  );

  regbank_dump_tx_if #(.DATA_SIZE(16), .REG_SIZE(RW), .BYTE_SIZE(BW)) bus2 ();
  regbank_dump_tx #(.DATA_SIZE(16), .REG_SIZE(RW), .NUM_REGS(1), .BYTE_SIZE(BW)) dut2 (
    .i_clock(clk), .i_reset(rst), .bus(bus2)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] bank_mem [NR];
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] exp2_q[$];
  int  exp_addr = 0;
  int  sent = 0;
  int  done_cnt = 0;
  int  done_cyc = 0;
  int  start_cyc = 0;
  int  first_tx_cyc = -1;
  int  ack_delay = 5;
  bit  spurious_ack = 1'b0;
  int  sent2 = 0;
  int  done2_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- bank model: data valid only in the cycle after the read enable
  initial begin : bank_model
    logic          pend;
    logic [RW-1:0] a;
    bus.i_rb_data = '0;
    forever begin
      @(negedge clk);
      pend = bus.o_rb_read_enable;
      a    = bus.o_rb_read_addr;
      @(posedge clk);
      #1;
      bus.i_rb_data = pend ? bank_mem[a] : DW'($urandom);
    end
  end

  initial begin : bank_model2
    logic          pend;
    logic [RW-1:0] a;
    bus2.i_rb_data = '0;
    forever begin
      @(negedge clk);
      pend = bus2.o_rb_read_enable;
      a    = bus2.o_rb_read_addr;
      @(posedge clk);
      #1;
      bus2.i_rb_data = pend ? ((a == '0) ? 16'h1234 : 16'hDEAD) : 16'($urandom);
    end
  end

  // ---------------- UART model: ack ack_delay cycles into the wait (negative = random)
  initial begin : uart_model
    int d;
    bus.i_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.o_tx_start && !rst) begin
        d = (ack_delay < 0) ? int'($urandom_range(0, 6)) : ack_delay;
        if (spurious_ack) bus.i_tx_done = 1'b1;
        @(posedge clk);
        #1 bus.i_tx_done = 1'b0;
        repeat (d) @(posedge clk);
        #1 bus.i_tx_done = 1'b1;
        @(posedge clk);
        #1 bus.i_tx_done = 1'b0;
      end
    end
  end

  initial begin : uart_model2
    bus2.i_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus2.o_tx_start && !rst) begin
        @(posedge clk);
        @(posedge clk);
        #1 bus2.i_tx_done = 1'b1;
        @(posedge clk);
        #1 bus2.i_tx_done = 1'b0;
      end
    end
  end

  // ---------------- monitor / scoreboard for the main instance
  initial begin : monitor
    logic          prev_en;
    logic [BW-1:0] last_byte;
    bit            busy_chk;
    prev_en = 1'b0; last_byte = '0; busy_chk = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_en = 1'b0; last_byte = '0; busy_chk = 1'b0;
      end else begin
        if (bus.o_rb_read_enable) begin
          check("rd_en_single_cycle", 64'(prev_en), 64'd0);
          check("rd_addr", 64'(bus.o_rb_read_addr), 64'(exp_addr));
          exp_addr++;
        end
        prev_en = bus.o_rb_read_enable;
        if (bus.o_tx_start) begin
          sent++;
          if (first_tx_cyc < 0) first_tx_cyc = cyc;
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL tx_unexpected: got byte %0h, expected no byte", bus.o_tx_data);
          end else begin
            check("tx_byte", 64'(bus.o_tx_data), 64'(exp_q.pop_front()));
          end
          last_byte = bus.o_tx_data;
        end else begin
          check("tx_data_hold", 64'(bus.o_tx_data), 64'(last_byte));
        end
        if (bus.o_done) begin
          done_cnt++;
          done_cyc = cyc;
          check("done_busy_high", 64'(bus.o_busy), 64'd1);
          check("done_queue_empty", 64'(exp_q.size()), 64'd0);
          check("done_all_regs_read", 64'(exp_addr), 64'(NR));
          busy_chk = 1'b1;
        end else if (busy_chk) begin
          check("busy_low_after_done", 64'(bus.o_busy), 64'd0);
          busy_chk = 1'b0;
        end
      end
    end
  end

  initial begin : monitor2
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus2.o_tx_start) begin
          sent2++;
          if (exp2_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL corner_tx_unexpected: got byte %0h, expected no byte", bus2.o_tx_data);
          end else begin
            check("corner_tx_byte", 64'(bus2.o_tx_data), 64'(exp2_q.pop_front()));
          end
        end
        if (bus2.o_done) begin
          done2_cnt++;
          check("corner_done_queue_empty", 64'(exp2_q.size()), 64'd0);
        end
      end
    end
  end

  // ---------------- drivers
  task automatic issue_dump(input int hold);
    logic [DW-1:0] w;
    @(negedge clk);
    for (int r = 0; r < NR; r++) begin
      w = bank_mem[r];
      for (int b = 0; b < NB; b++) exp_q.push_back(BW'(w >> (DW - BW * (b + 1))));
    end
    exp_addr = 0; sent = 0; first_tx_cyc = -1; start_cyc = cyc;
    bus.i_start = 1'b1;
    repeat (hold) @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int i = 0;
    while (done_cnt < target && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(name, 64'(done_cnt >= target), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_sent(input int target, input int budget, input string name);
    int i = 0;
    while (sent < target && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(name, 64'(sent >= target), 64'd1);
  endtask

  task automatic check_quiet(input string name);
    check({name, "_busy"},  64'(bus.o_busy), 64'd0);
    check({name, "_start"}, 64'(bus.o_tx_start), 64'd0);
    check({name, "_data"},  64'(bus.o_tx_data), 64'd0);
    check({name, "_rd_en"}, 64'(bus.o_rb_read_enable), 64'd0);
    check({name, "_addr"},  64'(bus.o_rb_read_addr), 64'd0);
    check({name, "_done"},  64'(bus.o_done), 64'd0);
  endtask

  initial begin : main
    int d0;
    bus.i_start  = 1'b0;
    bus2.i_start = 1'b0;
    for (int r = 0; r < NR; r++) bank_mem[r] = 32'hA0B0C0D0 + DW'(r);

    #3 rst = 1'b1;
    #1 check_quiet("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_quiet("idle");

    // basic dump, ack 5 cycles into each wait
    ack_delay = 5;
    issue_dump(1);
    wait_done(1, 4000, "basic_done_timeout");
    check("basic_bytes", 64'(sent), 64'(NR * NB));
    check("basic_done_count", 64'(done_cnt), 64'd1);

    // back-to-back acks, i_start held for several cycles
    ack_delay = 0;
    issue_dump(4);
    wait_done(2, 1000, "b2b_done_timeout");
    check("b2b_first_tx_latency", 64'(first_tx_cyc - start_cyc), 64'd3);
    check("b2b_duration", 64'(done_cyc - start_cyc), 64'd353);
    check("b2b_bytes", 64'(sent), 64'(NR * NB));
    check("b2b_done_count", 64'(done_cnt), 64'd2);

    // random bank contents, random ack latency, spurious start and SEND-cycle acks
    for (int r = 0; r < NR; r++) bank_mem[r] = DW'($urandom);
    ack_delay = -1;
    spurious_ack = 1'b1;
    issue_dump(1);
    wait_sent(10, 2000, "spur_reach_byte10");
    @(negedge clk);
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    wait_done(3, 4000, "spur_done_timeout");
    spurious_ack = 1'b0;
    check("spur_bytes", 64'(sent), 64'(NR * NB));
    check("spur_done_count", 64'(done_cnt), 64'd3);
    repeat (20) @(negedge clk);
    check("spur_no_restart", 64'(done_cnt), 64'd3);

    // asynchronous reset while waiting on register 7 byte 2
    for (int r = 0; r < NR; r++) bank_mem[r] = 32'hA0B0C0D0 + DW'(r);
    ack_delay = 5;
    issue_dump(1);
    wait_sent(7 * NB + 3, 2000, "rst_reach_reg7_byte2");
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_quiet("midreset");
    exp_q.delete();
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("midreset_no_done", 64'(done_cnt), 64'(d0));
    check("midreset_no_more_tx", 64'(sent), 64'(7 * NB + 3));
    issue_dump(1);
    wait_done(d0 + 1, 4000, "restart_done_timeout");
    check("restart_bytes", 64'(sent), 64'(NR * NB));

    // corner instance: one 16-bit register
    exp2_q.push_back(8'h12);
    exp2_q.push_back(8'h34);
    @(negedge clk);
    bus2.i_start = 1'b1;
    @(negedge clk);
    bus2.i_start = 1'b0;
    for (int i = 0; i < 100 && done2_cnt == 0; i++) @(negedge clk);
    check("corner_done_count", 64'(done2_cnt), 64'd1);
    check("corner_bytes", 64'(sent2), 64'd2);
    repeat (3) @(negedge clk);
    check("corner_busy_low", 64'(bus2.o_busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
